// File: rtl/envelope_bank_pkg.sv
// envelope_bank_pkg: envelope state encoding and sizing helpers shared by the envelope bank.
package envelope_bank_pkg;
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} envelope_state_t;
  function automatic int index_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] level_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/envelope_voice_step.sv
// envelope_voice_step: one ADSR step for a single voice; the datapath shared by every voice in the bank.
module envelope_voice_step import envelope_bank_pkg::*; #(
  parameter int LEVEL_WIDTH = 16
) (
  input  envelope_state_t        state,
  input  logic [LEVEL_WIDTH-1:0] level,
  input  logic                   pend_on,
  input  logic                   pend_off,
  input  logic [LEVEL_WIDTH-1:0] attack_rate,
  input  logic [LEVEL_WIDTH-1:0] decay_rate,
  input  logic [LEVEL_WIDTH-1:0] sustain_level,
  input  logic [LEVEL_WIDTH-1:0] release_rate,
  output envelope_state_t        next_state,
  output logic [LEVEL_WIDTH-1:0] next_level,
  output logic                   ended
);
  localparam logic [LEVEL_WIDTH-1:0] MAX = LEVEL_WIDTH'(level_max(LEVEL_WIDTH));
  logic [LEVEL_WIDTH:0] sum;
  logic a_hit, d_hit, r_hit;
  assign sum   = {1'b0, level} + {1'b0, attack_rate};
  assign a_hit = attack_rate == '0 || sum >= {1'b0, MAX};
  assign d_hit = decay_rate == '0 || level < decay_rate || level - decay_rate <= sustain_level;
  assign r_hit = release_rate == '0 || level <= release_rate;
  // Note events only change the segment; the level carries over so retrigger and release are click-free.
  always_comb begin
    next_state = state;
    next_level = level;
    ended = 1'b0;
    if (pend_on) next_state = ATTACK;
    else if (pend_off && state inside {ATTACK, DECAY, SUSTAIN}) next_state = RELEASE;
    else case (state)
      ATTACK: begin
        next_state = a_hit ? DECAY : ATTACK;
        next_level = a_hit ? MAX : sum[LEVEL_WIDTH-1:0];
      end
      DECAY: begin
        next_state = d_hit ? SUSTAIN : DECAY;
        next_level = d_hit ? sustain_level : level - decay_rate;
      end
      SUSTAIN: next_level = sustain_level;
      RELEASE: begin
        next_state = r_hit ? IDLE : RELEASE;
        next_level = r_hit ? '0 : level - release_rate;
        ended = r_hit;
      end
      default: next_level = '0;
    endcase
  end
endmodule

// File: rtl/envelope_bank.sv
// envelope_bank: polyphonic linear ADSR generator; one shared step datapath sweeps all voices once per
// generation tick while note events are latched per voice until that voice's turn.
module envelope_bank import envelope_bank_pkg::*; #(
  parameter int NUM_VOICES                 = 8,
  parameter int LEVEL_WIDTH                = 16,
  parameter int SYSTEM_CLOCK               = 50_000_000,
  parameter int AUDIO_GENERATION_FREQUENCY = 48_000,
  parameter int TICK_DIV                   = SYSTEM_CLOCK / AUDIO_GENERATION_FREQUENCY
) (
  input  logic                              clock_50_000_000,
  input  logic                              reset_l,
  input  logic [NUM_VOICES-1:0]             note_on,
  input  logic [NUM_VOICES-1:0]             note_off,
  input  logic [LEVEL_WIDTH-1:0]            attack_rate,
  input  logic [LEVEL_WIDTH-1:0]            decay_rate,
  input  logic [LEVEL_WIDTH-1:0]            sustain_level,
  input  logic [LEVEL_WIDTH-1:0]            release_rate,
  output logic [NUM_VOICES*LEVEL_WIDTH-1:0] envelope,
  output logic [NUM_VOICES-1:0]             envelope_end,
  output logic [NUM_VOICES-1:0]             active,
  output logic                              sweep_done
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = index_width(NUM_VOICES);
  localparam logic [CW-1:0] LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] VLAST = CW'(NUM_VOICES - 1);
  logic [CW-1:0] cnt;
  logic started, busy, ended;
  logic [IW-1:0] s;
  logic [NUM_VOICES-1:0] pend_on, pend_off, clr;
  envelope_state_t state [NUM_VOICES];
  logic [LEVEL_WIDTH-1:0] level [NUM_VOICES];
  envelope_state_t next_state;
  logic [LEVEL_WIDTH-1:0] next_level;
  // The sweep runs on tick counts 0..NUM_VOICES-1, but only after the counter has wrapped once.
  assign busy = started && cnt <= VLAST;
  assign s    = cnt[IW-1:0];
  assign clr  = busy ? NUM_VOICES'(1) << s : '0;
  envelope_voice_step #(.LEVEL_WIDTH(LEVEL_WIDTH)) step (
    .state(state[s]), .level(level[s]), .pend_on(pend_on[s]), .pend_off(pend_off[s]),
    .attack_rate(attack_rate), .decay_rate(decay_rate), .sustain_level(sustain_level),
    .release_rate(release_rate), .next_state(next_state), .next_level(next_level), .ended(ended)
  );
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      cnt <= '0;
      started <= 1'b0;
      sweep_done <= 1'b0;
      envelope_end <= '0;
      pend_on <= '0;
      pend_off <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        state[i] <= IDLE;
        level[i] <= '0;
      end
    end else begin
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      started <= started || cnt == LAST;
      sweep_done <= started && cnt == VLAST;
      envelope_end <= clr & {NUM_VOICES{ended}};
      pend_on <= note_on | (pend_on & ~note_off & ~clr);
      pend_off <= ~note_on & (note_off | (pend_off & ~clr));
      if (busy) begin
        state[s] <= next_state;
        level[s] <= next_level;
      end
    end
  end
  always_comb begin
    envelope = '0;
    active = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      envelope[i*LEVEL_WIDTH +: LEVEL_WIDTH] = level[i];
      active[i] = state[i] != IDLE;
    end
  end
endmodule
